ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_if.sv | 48 ++++
 rtl/ram_arbiter.sv | 104 ++++++++++
 tb/tb_ram_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_if
// Description : Request/response bundle between two requesters, the arbiter
//               and a shared single-port RAM.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if;
    logic        m0_valid;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_wstrb;
    logic [31:0] m0_rdata;
    logic        m0_ready;

    logic        m1_valid;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wstrb;
    logic [31:0] m1_rdata;
    logic        m1_ready;

    logic        ram_valid;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wstrb;
    logic [31:0] ram_rdata;
    logic        ram_ready;

    // Arbiter side
    modport slave (
        input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
        input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
        input  ram_rdata, ram_ready,
        output m0_rdata, m0_ready, m1_rdata, m1_ready,
        output ram_valid, ram_addr, ram_wdata, ram_wstrb
    );

    // Requester and RAM side
    modport master (
        output m0_valid, m0_addr, m0_wdata, m0_wstrb,
        output m1_valid, m1_addr, m1_wdata, m1_wstrb,
        output ram_rdata, ram_ready,
        input  m0_rdata, m0_ready, m1_rdata, m1_ready,
        input  ram_valid, ram_addr, ram_wdata, ram_wstrb
    );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Two-requester arbiter for a shared single-port RAM with
//               round-robin or fixed (m0-first) priority.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int ROUND_ROBIN = 1
) (
    input  wire logic     clk,
    input  wire logic     resetn,
    ram_arbiter_if.slave  bus
);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_BUSY0 = 2'd1;
    localparam logic [1:0] c_BUSY1 = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       r_last_grant;
    logic       w_next_last_grant;
    logic [3:0] w_wstrb;

    // last_grant resets to 1 so that m0 wins the first contended decision
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= c_IDLE;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_next_last_grant;
        end
    end

    always_comb begin
        w_next_state      = r_state;
        w_next_last_grant = r_last_grant;
        case (r_state)
            c_IDLE: begin
                if (bus.m0_valid && bus.m1_valid) begin
                    w_next_state = ((ROUND_ROBIN != 0) && !r_last_grant) ? c_BUSY1 : c_BUSY0;
                end else if (bus.m0_valid) begin
                    w_next_state = c_BUSY0;
                end else if (bus.m1_valid) begin
                    w_next_state = c_BUSY1;
                end
            end
            c_BUSY0: begin
                // An abandoned request leaves last_grant untouched
                if (!bus.m0_valid) begin
                    w_next_state = c_IDLE;
                end else if (bus.ram_ready) begin
                    w_next_state      = c_IDLE;
                    w_next_last_grant = 1'b0;
                end
            end
            c_BUSY1: begin
                if (!bus.m1_valid) begin
                    w_next_state = c_IDLE;
                end else if (bus.ram_ready) begin
                    w_next_state      = c_IDLE;
                    w_next_last_grant = 1'b1;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        bus.ram_valid = 1'b0;
        bus.ram_addr  = 32'h0;
        bus.ram_wdata = 32'h0;
        w_wstrb       = 4'b0000;
        bus.m0_ready  = 1'b0;
        bus.m1_ready  = 1'b0;
        bus.m0_rdata  = 32'h0;
        bus.m1_rdata  = 32'h0;
        case (r_state)
            c_BUSY0: begin
                bus.ram_valid = bus.m0_valid;
                bus.ram_addr  = bus.m0_addr;
                bus.ram_wdata = bus.m0_wdata;
                w_wstrb       = bus.m0_wstrb;
                bus.m0_ready  = bus.ram_ready & bus.m0_valid;
                bus.m0_rdata  = bus.ram_rdata;
            end
            c_BUSY1: begin
                bus.ram_valid = bus.m1_valid;
                bus.ram_addr  = bus.m1_addr;
                bus.ram_wdata = bus.m1_wdata;
                w_wstrb       = bus.m1_wstrb;
                bus.m1_ready  = bus.ram_ready & bus.m1_valid;
                bus.m1_rdata  = bus.ram_rdata;
            end
            default: ;
        endcase
    end

    // Byte enables are suppressed whenever no access is strobed
    assign bus.ram_wstrb = bus.ram_valid ? w_wstrb : 4'b0000;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Self-checking bench for ram_arbiter (round-robin and fixed).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ram_arbiter_if rr_if();
    ram_arbiter_if fp_if();

    ram_arbiter #(.ROUND_ROBIN(1)) dut_rr (.clk(clk), .resetn(resetn), .bus(rr_if.slave));
    ram_arbiter #(.ROUND_ROBIN(0)) dut_fp (.clk(clk), .resetn(resetn), .bus(fp_if.slave));

    // Shared RAM behind the round-robin instance: combinational read, write on edge
    logic [31:0] mem [0:63];
    assign rr_if.ram_rdata = mem[rr_if.ram_addr[7:2]];
    assign fp_if.ram_ready = 1'b1;
    assign fp_if.ram_rdata = 32'h0;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
        forever begin
            @(posedge clk);
            if (rr_if.ram_valid && rr_if.ram_ready)
                for (int b = 0; b < 4; b++)
                    if (rr_if.ram_wstrb[b]) mem[rr_if.ram_addr[7:2]][b*8 +: 8] = rr_if.ram_wdata[b*8 +: 8];
        end
    end

    task automatic set_m0(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        rr_if.m0_valid = v; rr_if.m0_addr = a; rr_if.m0_wdata = d; rr_if.m0_wstrb = s;
    endtask

    task automatic set_m1(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        rr_if.m1_valid = v; rr_if.m1_addr = a; rr_if.m1_wdata = d; rr_if.m1_wstrb = s;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        set_m0(1'b1, 32'h44, 32'h1234_5678, 4'hF);
        set_m1(1'b1, 32'h48, 32'hCAFE_F00D, 4'h3);
        rr_if.ram_ready = 1'b1;
        fp_if.m0_valid = 1'b1; fp_if.m1_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (rr_if.ram_valid !== 1'b0) begin failures++; $display("FAIL reset_ram_valid got=%b exp=0", rr_if.ram_valid); end
        checks++; if (rr_if.ram_wstrb !== 4'h0) begin failures++; $display("FAIL reset_ram_wstrb got=%h exp=0", rr_if.ram_wstrb); end
        checks++; if (rr_if.ram_addr !== 32'h0) begin failures++; $display("FAIL reset_ram_addr got=%h exp=0", rr_if.ram_addr); end
        checks++; if (rr_if.ram_wdata !== 32'h0) begin failures++; $display("FAIL reset_ram_wdata got=%h exp=0", rr_if.ram_wdata); end
        checks++; if (rr_if.m0_ready !== 1'b0 || rr_if.m1_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b%b exp=00", rr_if.m0_ready, rr_if.m1_ready); end
        checks++; if (rr_if.m0_rdata !== 32'h0 || rr_if.m1_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0", rr_if.m0_rdata, rr_if.m1_rdata); end
        checks++; if (fp_if.ram_valid !== 1'b0 || fp_if.m0_ready !== 1'b0) begin failures++; $display("FAIL reset_fp_out got=%b%b exp=00", fp_if.ram_valid, fp_if.m0_ready); end
        set_m0(1'b0, 32'h0, 32'h0, 4'h0);
        set_m1(1'b0, 32'h0, 32'h0, 4'h0);
        fp_if.m0_valid = 1'b0; fp_if.m1_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        set_m0(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        #1;
        checks++; if (rr_if.ram_valid !== 1'b0 || rr_if.m0_ready !== 1'b0) begin failures++; $display("FAIL wr_idle_cycle got=%b%b exp=00", rr_if.ram_valid, rr_if.m0_ready); end
        @(negedge clk); #1;
        checks++; if (rr_if.ram_valid !== 1'b1 || rr_if.m0_ready !== 1'b1) begin failures++; $display("FAIL wr_latency got=%b%b exp=11", rr_if.ram_valid, rr_if.m0_ready); end
        checks++; if (rr_if.ram_addr !== 32'h10 || rr_if.ram_wdata !== 32'hDEAD_BEEF || rr_if.ram_wstrb !== 4'hF) begin failures++; $display("FAIL wr_fields got=%h/%h/%h exp=10/deadbeef/f", rr_if.ram_addr, rr_if.ram_wdata, rr_if.ram_wstrb); end
        @(negedge clk);
        set_m0(1'b1, 32'h10, 32'h0, 4'h0);
        #1;
        checks++; if (rr_if.m0_ready !== 1'b0) begin failures++; $display("FAIL rd_idle_cycle got=%b exp=0", rr_if.m0_ready); end
        @(negedge clk); #1;
        checks++; if (rr_if.m0_ready !== 1'b1 || rr_if.m0_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_data got=%b/%h exp=1/deadbeef", rr_if.m0_ready, rr_if.m0_rdata); end
        checks++; if (rr_if.ram_wstrb !== 4'h0 || rr_if.m1_rdata !== 32'h0) begin failures++; $display("FAIL rd_side got=%h/%h exp=0/0", rr_if.ram_wstrb, rr_if.m1_rdata); end
        @(negedge clk);
        set_m0(1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_back_to_back();
        int n0 = 0;
        int n1 = 0;
        int cyc = 0;
        int order[$];
        int got;
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rr_if.ram_ready = 1'b1;
        set_m0(1'b1, 32'h80, 32'h0000_0100, 4'hF);
        set_m1(1'b1, 32'hC0, 32'h0000_0200, 4'hF);
        resetn = 1'b1;
        while ((n0 < 4 || n1 < 4) && cyc < 40) begin
            #1;
            cyc++;
            if (rr_if.m0_ready === 1'b1) begin order.push_back(0); n0++; end
            if (rr_if.m1_ready === 1'b1) begin order.push_back(1); n1++; end
            @(negedge clk);
            set_m0(n0 < 4, 32'h80 + 32'(n0 * 4), 32'h0000_0100 + 32'(n0), 4'hF);
            set_m1(n1 < 4, 32'hC0 + 32'(n1 * 4), 32'h0000_0200 + 32'(n1), 4'hF);
        end
        checks++; if (cyc !== 16) begin failures++; $display("FAIL b2b_cycles got=%0d exp=16", cyc); end
        checks++; if (order.size() !== 8) begin failures++; $display("FAIL b2b_grants got=%0d exp=8", order.size()); end
        for (int i = 0; i < 8; i++) begin
            got = (i < order.size()) ? order[i] : -1;
            checks++; if (got !== i % 2) begin failures++; $display("FAIL b2b_order[%0d] got=%0d exp=%0d", i, got, i % 2); end
        end
    endtask

    task automatic test_fixed_priority();
        int n0 = 0;
        int served1 = 0;
        @(negedge clk);
        fp_if.m0_valid = 1'b1; fp_if.m0_addr = 32'h4; fp_if.m0_wdata = 32'h0; fp_if.m0_wstrb = 4'h0;
        fp_if.m1_valid = 1'b1; fp_if.m1_addr = 32'h8; fp_if.m1_wdata = 32'h0; fp_if.m1_wstrb = 4'h0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (fp_if.m0_ready === 1'b1) n0++;
            checks++; if (fp_if.m1_ready !== 1'b0) begin failures++; $display("FAIL fp_m1_blocked cyc=%0d got=%b exp=0", i, fp_if.m1_ready); end
            @(negedge clk);
        end
        checks++; if (n0 !== 10) begin failures++; $display("FAIL fp_m0_grants got=%0d exp=10", n0); end
        fp_if.m0_valid = 1'b0;
        for (int i = 0; i < 4 && served1 == 0; i++) begin
            #1;
            if (fp_if.m1_ready === 1'b1) served1 = 1;
            @(negedge clk);
        end
        checks++; if (served1 !== 1) begin failures++; $display("FAIL fp_m1_after_m0 got=%0d exp=1", served1); end
        fp_if.m1_valid = 1'b0;
    endtask

    task automatic test_wait_states();
        @(negedge clk);
        rr_if.ram_ready = 1'b0;
        set_m1(1'b1, 32'h30, 32'h0, 4'h0);
        @(negedge clk);
        set_m0(1'b1, 32'h34, 32'h5555_AAAA, 4'hF);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++; if (rr_if.m1_ready !== 1'b0 || rr_if.m0_ready !== 1'b0) begin failures++; $display("FAIL ws_stall[%0d] got=%b%b exp=00", i, rr_if.m0_ready, rr_if.m1_ready); end
            checks++; if (rr_if.ram_valid !== 1'b1 || rr_if.ram_addr !== 32'h30 || rr_if.m0_rdata !== 32'h0) begin failures++; $display("FAIL ws_bus[%0d] got=%b/%h/%h exp=1/30/0", i, rr_if.ram_valid, rr_if.ram_addr, rr_if.m0_rdata); end
        end
        @(negedge clk);
        rr_if.ram_ready = 1'b1;
        #1;
        checks++; if (rr_if.m1_ready !== 1'b1 || rr_if.m0_ready !== 1'b0) begin failures++; $display("FAIL ws_release got=%b%b exp=01", rr_if.m0_ready, rr_if.m1_ready); end
        checks++; if (rr_if.m1_rdata !== 32'hA5A5_000C) begin failures++; $display("FAIL ws_rdata got=%h exp=a5a5000c", rr_if.m1_rdata); end
        @(negedge clk);
        set_m1(1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        checks++; if (rr_if.m0_ready !== 1'b0) begin failures++; $display("FAIL ws_m0_idle got=%b exp=0", rr_if.m0_ready); end
        @(negedge clk); #1;
        checks++; if (rr_if.m0_ready !== 1'b1) begin failures++; $display("FAIL ws_m0_served got=%b exp=1", rr_if.m0_ready); end
        @(negedge clk);
        set_m0(1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        set_m0(1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk); #1;
        checks++; if (rr_if.ram_valid !== 1'b1) begin failures++; $display("FAIL abort_busy got=%b exp=1", rr_if.ram_valid); end
        resetn = 1'b0;
        #1;
        checks++; if (rr_if.ram_valid !== 1'b0 || rr_if.ram_wstrb !== 4'h0 || rr_if.m0_ready !== 1'b0) begin failures++; $display("FAIL abort_outputs got=%b/%h/%b exp=0/0/0", rr_if.ram_valid, rr_if.ram_wstrb, rr_if.m0_ready); end
        checks++; if (rr_if.ram_addr !== 32'h0 || rr_if.ram_wdata !== 32'h0 || rr_if.m0_rdata !== 32'h0) begin failures++; $display("FAIL abort_fields got=%h/%h/%h exp=0/0/0", rr_if.ram_addr, rr_if.ram_wdata, rr_if.m0_rdata); end
        @(negedge clk);
        set_m0(1'b0, 32'h0, 32'h0, 4'h0);
        resetn = 1'b1;
        @(negedge clk); #1;
        checks++; if (mem[8] !== 32'hA5A5_0008) begin failures++; $display("FAIL abort_mem got=%h exp=a5a50008", mem[8]); end
    endtask

    task automatic test_abandon();
        @(negedge clk);
        set_m0(1'b1, 32'h24, 32'h1111_2222, 4'hF);
        @(negedge clk);
        set_m0(1'b0, 32'h24, 32'h1111_2222, 4'hF);
        set_m1(1'b1, 32'h28, 32'h0, 4'h0);
        #1;
        checks++; if (rr_if.ram_valid !== 1'b0 || rr_if.ram_wstrb !== 4'h0) begin failures++; $display("FAIL abandon_bus got=%b/%h exp=0/0", rr_if.ram_valid, rr_if.ram_wstrb); end
        checks++; if (rr_if.m0_ready !== 1'b0 || rr_if.m1_ready !== 1'b0) begin failures++; $display("FAIL abandon_ready got=%b%b exp=00", rr_if.m0_ready, rr_if.m1_ready); end
        @(negedge clk); #1;
        checks++; if (rr_if.m1_ready !== 1'b0) begin failures++; $display("FAIL abandon_idle got=%b exp=0", rr_if.m1_ready); end
        @(negedge clk); #1;
        checks++; if (rr_if.m1_ready !== 1'b1 || rr_if.m1_rdata !== 32'hA5A5_000A) begin failures++; $display("FAIL abandon_m1 got=%b/%h exp=1/a5a5000a", rr_if.m1_ready, rr_if.m1_rdata); end
        @(negedge clk);
        set_m1(1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        checks++; if (mem[9] !== 32'hA5A5_0009) begin failures++; $display("FAIL abandon_mem got=%h exp=a5a50009", mem[9]); end
    endtask

    // Transaction-level model: one owner at a time, ownership handed out when the
    // bus is free, alternating under contention, released on completion/abandon.
    task automatic test_random();
        logic [31:0] ref_mem [64];
        logic        v [2];
        logic [31:0] a [2];
        logic [31:0] d [2];
        logic [3:0]  s [2];
        logic        exp_rdy [2];
        logic        got_rdy [2];
        logic [31:0] got_rd [2];
        logic        exp_rv;
        logic [3:0]  exp_ws;
        int          owner = -1;
        int          last = 1;
        int          idx;
        int          bad_words = 0;
        resetn = 1'b0;
        set_m0(1'b0, 32'h0, 32'h0, 4'h0);
        set_m1(1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
        for (int r = 0; r < 2; r++) begin v[r] = 1'b0; a[r] = 32'h0; d[r] = 32'h0; s[r] = 4'h0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                if (!v[r] && $urandom_range(0, 2) != 0) begin
                    v[r] = 1'b1;
                    a[r] = 32'($urandom_range(0, 63)) << 2;
                    d[r] = $urandom;
                    s[r] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                end
            end
            set_m0(v[0], a[0], d[0], s[0]);
            set_m1(v[1], a[1], d[1], s[1]);
            rr_if.ram_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rv = 1'b0; exp_ws = 4'h0; exp_rdy[0] = 1'b0; exp_rdy[1] = 1'b0;
            if (owner >= 0) begin
                exp_rv = v[owner];
                exp_ws = v[owner] ? s[owner] : 4'h0;
                exp_rdy[owner] = v[owner] & rr_if.ram_ready;
            end
            got_rdy[0] = rr_if.m0_ready; got_rdy[1] = rr_if.m1_ready;
            got_rd[0] = rr_if.m0_rdata;  got_rd[1] = rr_if.m1_rdata;
            checks++; if (rr_if.ram_valid !== exp_rv || rr_if.ram_wstrb !== exp_ws) begin failures++; $display("FAIL rnd_bus cyc=%0d got=%b/%h exp=%b/%h", cyc, rr_if.ram_valid, rr_if.ram_wstrb, exp_rv, exp_ws); end
            checks++; if (got_rdy[0] !== exp_rdy[0] || got_rdy[1] !== exp_rdy[1]) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b%b exp=%b%b", cyc, got_rdy[0], got_rdy[1], exp_rdy[0], exp_rdy[1]); end
            if (exp_rv) begin
                checks++; if (rr_if.ram_addr !== a[owner]) begin failures++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, rr_if.ram_addr, a[owner]); end
            end
            for (int r = 0; r < 2; r++) begin
                if (r != owner) begin
                    checks++; if (got_rd[r] !== 32'h0) begin failures++; $display("FAIL rnd_rdata_idle m%0d cyc=%0d got=%h exp=0", r, cyc, got_rd[r]); end
                end else if (exp_rdy[r]) begin
                    idx = int'(a[r][7:2]);
                    checks++; if (got_rd[r] !== ref_mem[idx]) begin failures++; $display("FAIL rnd_rdata m%0d cyc=%0d got=%h exp=%h", r, cyc, got_rd[r], ref_mem[idx]); end
                end
            end
            // Advance the model across the coming clock edge
            if (owner >= 0) begin
                if (exp_rdy[owner]) begin
                    idx = int'(a[owner][7:2]);
                    for (int b = 0; b < 4; b++)
                        if (s[owner][b]) ref_mem[idx][b*8 +: 8] = d[owner][b*8 +: 8];
                    last = owner;
                    v[owner] = 1'b0;
                    owner = -1;
                end else if (!v[owner]) begin
                    owner = -1;
                end
            end else if (v[0] && v[1]) begin
                owner = (last == 0) ? 1 : 0;
            end else if (v[0]) begin
                owner = 0;
            end else if (v[1]) begin
                owner = 1;
            end
        end
        @(negedge clk);
        set_m0(1'b0, 32'h0, 32'h0, 4'h0);
        set_m1(1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad_words++;
        checks++; if (bad_words !== 0) begin failures++; $display("FAIL rnd_mem_image got=%0d bad words exp=0", bad_words); end
    endtask

    initial begin
        set_m0(1'b0, 32'h0, 32'h0, 4'h0);
        set_m1(1'b0, 32'h0, 32'h0, 4'h0);
        rr_if.ram_ready = 1'b1;
        fp_if.m0_valid = 1'b0; fp_if.m0_addr = 32'h0; fp_if.m0_wdata = 32'h0; fp_if.m0_wstrb = 4'h0;
        fp_if.m1_valid = 1'b0; fp_if.m1_addr = 32'h0; fp_if.m1_wdata = 32'h0; fp_if.m1_wstrb = 4'h0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_fixed_priority();
        test_wait_states();
        test_reset_abort();
        test_abandon();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
